// File: rtl/sprite_pkg.sv
// Shared types and constants for the board sprite loader.
// Pixels are RGB888 colours, and each one is stored in the sprite RAM as a 4-bit palette index.
package sprite_pkg;

  localparam int BOARD_DEPTH   = 816;
  localparam int SPRITE_ADDR_W = 10;

  typedef logic [23:0]              rgb_t;
  typedef logic [3:0]               pal_idx_t;
  typedef logic [SPRITE_ADDR_W-1:0] sprite_addr_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FIN
  } loader_state_t;

endpackage

// File: rtl/board_sprite_loader_if.sv
// Pixel stream in and index-RAM write port out.
// The master side is the pixel source and RAM; the slave side is the loader.
interface board_sprite_loader_if;
  import sprite_pkg::*;

  logic         pix_valid;
  rgb_t         pix_rgb;
  logic         pix_ready;
  logic         wr_en;
  sprite_addr_t wr_addr;
  pal_idx_t     wr_data;

  modport master (
    output pix_valid, pix_rgb,
    input  pix_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  pix_valid, pix_rgb,
    output pix_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/palette_encoder.sv
// Combinational RGB-to-palette-index lookup using an exact 24-bit compare.
// When several entries match, the lowest index wins. Only the first NCOL entries take part.
module palette_encoder
  import sprite_pkg::*;
#(
  parameter int   NCOL = 3,
  parameter rgb_t PAL0 = 24'h9a12a2,
  parameter rgb_t PAL1 = 24'h000000,
  parameter rgb_t PAL2 = 24'hdcdcd9
) (
  input  rgb_t     rgb,
  output pal_idx_t idx,
  output logic     hit
);

  always_comb begin
    idx = '0;
    hit = 1'b0;
    if (NCOL > 0 && rgb == PAL0) begin
      idx = 4'd0;
      hit = 1'b1;
    end else if (NCOL > 1 && rgb == PAL1) begin
      idx = 4'd1;
      hit = 1'b1;
    end else if (NCOL > 2 && rgb == PAL2) begin
      idx = 4'd2;
      hit = 1'b1;
    end
  end

endmodule

// File: rtl/board_sprite_loader.sv
// Streams DEPTH RGB pixels into the external sprite index RAM as palette indices.
// Unmatched colours are flagged, and the first offending address is remembered.
module board_sprite_loader
  import sprite_pkg::*;
#(
  parameter int   DEPTH = BOARD_DEPTH,
  parameter int   NCOL  = 3,
  parameter rgb_t PAL0  = 24'h9a12a2,
  parameter rgb_t PAL1  = 24'h000000,
  parameter rgb_t PAL2  = 24'hdcdcd9
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic                        start,
  board_sprite_loader_if.slave        bus,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output sprite_addr_t                err_addr
);

  localparam sprite_addr_t LAST = sprite_addr_t'(DEPTH - 1);

  loader_state_t state_q, state_d;
  sprite_addr_t  count_q, count_d;
  logic          pix_ready_q, pix_ready_d;
  logic          wr_en_q, wr_en_d;
  sprite_addr_t  wr_addr_q, wr_addr_d;
  pal_idx_t      wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  sprite_addr_t  err_addr_q, err_addr_d;

  pal_idx_t enc_idx;
  logic     enc_hit;
  logic     accept;

  palette_encoder #(
    .NCOL (NCOL),
    .PAL0 (PAL0),
    .PAL1 (PAL1),
    .PAL2 (PAL2)
  ) u_encoder (
    .rgb (bus.pix_rgb),
    .idx (enc_idx),
    .hit (enc_hit)
  );

  // pix_ready_q is high exactly while in LOAD, so it alone qualifies acceptance.
  assign accept = bus.pix_valid & pix_ready_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_addr_d = err_addr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = LOAD;
          count_d    = '0;
          err_d      = 1'b0;
          err_addr_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = count_q;
          wr_data_d = enc_hit ? enc_idx : '0;
          if (!enc_hit) begin
            err_d = 1'b1;
            if (!err_q) err_addr_d = count_q;
          end
          // The final pixel parks the counter at LAST, and done rides along with the last write.
          if (count_q == LAST) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    pix_ready_d = (state_d == LOAD);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      pix_ready_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      pix_ready_q <= pix_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign bus.pix_ready = pix_ready_q;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_addr      = err_addr_q;

endmodule

// File: tb/tb_board_sprite_loader.sv
// Randomized bench for board_sprite_loader.
// Every observed write is compared against a transaction-level palette model of the accepted pixels.
module tb_board_sprite_loader;

  localparam int DEPTH = 816;
  localparam int NCOL  = 3;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, err;
  logic [9:0]  err_addr;

  board_sprite_loader_if bus_if ();

  board_sprite_loader dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .start    (start),
    .bus      (bus_if),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_addr (err_addr)
  );

  always #5 Clk = ~Clk;

  logic [23:0] pal [3] = '{24'h9a12a2, 24'h000000, 24'hdcdcd9};

  int vectors = 0;
  int miscompares = 0;

  // Write monitor: records every strobe, its cycle, and each done pulse.
  int          cyc = 0;
  logic [9:0]  wr_addr_log [$];
  logic [3:0]  wr_data_log [$];
  int          wr_cyc_log  [$];
  int          done_cnt = 0;
  int          done_addr = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (bus_if.wr_en) begin
      wr_addr_log.push_back(bus_if.wr_addr);
      wr_data_log.push_back(bus_if.wr_data);
      wr_cyc_log.push_back(cyc);
    end
    if (done) begin
      done_cnt  = done_cnt + 1;
      done_addr = int'(bus_if.wr_addr);
    end
  end

  task automatic check_output(input string tag, input int obs, input int expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Reference palette lookup: the first matching entry wins, and -1 means no match.
  function automatic int exp_idx(input logic [23:0] c);
    for (int i = 0; i < NCOL; i++)
      if (pal[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [23:0] gen_colour(input int mode, input int i);
    int r;
    logic [23:0] c;
    c = pal[i % 3];
    if (mode == 1) begin
      r = int'($urandom_range(15));
      c = (r == 0) ? 24'($urandom()) : pal[r % 3];
    end else if (mode == 2) begin
      if (i == 5) c = 24'h123456;
      else if (i == 9) c = 24'hffffff;
    end
    return c;
  endfunction

  task automatic check_all_zero(input string tag);
    check_output({tag, "_busy"},      int'(busy), 0);
    check_output({tag, "_done"},      int'(done), 0);
    check_output({tag, "_err"},       int'(err), 0);
    check_output({tag, "_err_addr"},  int'(err_addr), 0);
    check_output({tag, "_pix_ready"}, int'(bus_if.pix_ready), 0);
    check_output({tag, "_wr_en"},     int'(bus_if.wr_en), 0);
    check_output({tag, "_wr_addr"},   int'(bus_if.wr_addr), 0);
    check_output({tag, "_wr_data"},   int'(bus_if.wr_data), 0);
  endtask

  // One load: start, then stream pixels until DEPTH are accepted (or abort by reset at abort_at).
  task automatic apply_load(input int mode, input int prob, input int start_at,
                            input int abort_at, input bit valid_on_start);
    logic [23:0] acc [$];
    int          acc_cyc [$];
    logic [23:0] c;
    int base_w, base_d, budget, first_unm, nw, bad;

    base_w = wr_addr_log.size();
    base_d = done_cnt;

    @(negedge Clk);
    start = 1'b1;
    bus_if.pix_valid = valid_on_start;
    bus_if.pix_rgb   = 24'hdcdcd9;
    @(negedge Clk);
    start = 1'b0;
    check_output("busy_after_start", int'(busy), 1);
    check_output("ready_in_load",    int'(bus_if.pix_ready), 1);
    check_output("err_cleared",      int'(err), 0);
    check_output("err_addr_cleared", int'(err_addr), 0);

    budget = 0;
    while (acc.size() < DEPTH && budget < 4 * DEPTH) begin
      if (acc.size() == abort_at) begin
        bus_if.pix_valid = 1'b1;
        bus_if.pix_rgb   = pal[0];
        #3 Reset_n = 1'b0;
        #1 check_all_zero("reset_mid_load");
        nw = wr_addr_log.size();
        repeat (2) @(negedge Clk);
        #3 Reset_n = 1'b1;
        repeat (3) @(negedge Clk);
        check_output("no_write_after_reset", wr_addr_log.size() - nw, 0);
        check_output("idle_after_reset_busy", int'(busy), 0);
        check_output("idle_after_reset_ready", int'(bus_if.pix_ready), 0);
        bus_if.pix_valid = 1'b0;
        return;
      end
      bus_if.pix_valid = (prob >= 100) ? 1'b1 : (int'($urandom_range(99)) < prob);
      c = gen_colour(mode, acc.size());
      bus_if.pix_rgb = c;
      start = (acc.size() == start_at);
      if (bus_if.pix_valid && bus_if.pix_ready) begin
        acc.push_back(c);
        acc_cyc.push_back(cyc + 1);
      end
      @(negedge Clk);
      budget++;
    end
    start = 1'b0;
    bus_if.pix_valid = 1'b0;
    repeat (3) @(negedge Clk);

    check_output("accepted_count", acc.size(), DEPTH);
    check_output("write_count", wr_addr_log.size() - base_w, acc.size());
    bad = miscompares;
    for (int k = 0; k < acc.size() && base_w + k < wr_addr_log.size(); k++) begin
      check_output("wr_addr", int'(wr_addr_log[base_w + k]), k);
      check_output("wr_data", int'(wr_data_log[base_w + k]),
                   (exp_idx(acc[k]) < 0) ? 0 : exp_idx(acc[k]));
      check_output("wr_latency", wr_cyc_log[base_w + k], acc_cyc[k]);
      if (miscompares != bad) break;
    end
    check_output("done_pulses", done_cnt - base_d, 1);
    check_output("done_addr", done_addr, DEPTH - 1);
    check_output("busy_after_done", int'(busy), 0);
    check_output("ready_after_done", int'(bus_if.pix_ready), 0);

    first_unm = -1;
    for (int k = 0; k < acc.size(); k++)
      if (first_unm < 0 && exp_idx(acc[k]) < 0) first_unm = k;
    check_output("err_flag", int'(err), (first_unm >= 0) ? 1 : 0);
    check_output("err_addr", int'(err_addr), (first_unm >= 0) ? first_unm : 0);

    if (prob >= 100 && acc_cyc.size() == DEPTH)
      check_output("no_bubbles", acc_cyc[DEPTH - 1] - acc_cyc[0], DEPTH - 1);
  endtask

  initial begin
    void'($urandom(1));
    bus_if.pix_valid = 1'b0;
    bus_if.pix_rgb   = '0;

    #2 check_all_zero("reset");
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    check_output("idle_busy", int'(busy), 0);
    check_output("idle_ready", int'(bus_if.pix_ready), 0);

    $display("[TB] scenario 1: back-to-back palette cycle");
    apply_load(0, 100, -1, -1, 1'b0);
    $display("[TB] scenario 2: random pix_valid and colours");
    apply_load(1, 50, -1, -1, 1'b0);
    $display("[TB] scenario 3: unmatched colours at 5 and 9");
    apply_load(2, 100, -1, -1, 1'b0);
    check_output("err_held_after_done", int'(err), 1);
    check_output("err_addr_is_5", int'(err_addr), 5);
    $display("[TB] scenario 4: start pulsed mid-load");
    apply_load(0, 100, 100, -1, 1'b0);
    $display("[TB] scenario 5: reset at count 300, then reload");
    apply_load(2, 100, -1, 300, 1'b0);
    apply_load(0, 100, -1, -1, 1'b0);
    $display("[TB] scenario 6: start with pix_valid in IDLE");
    apply_load(0, 100, -1, -1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/board_sprite_loader.md
BOARD_SPRITE_LOADER -- requirements
Module: board_sprite_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 816, giving the number of sprite pixels per load.
REQ-002 The block SHALL have parameter NCOL, default 3, giving the number of valid palette entries.
REQ-003 The block SHALL have parameters PAL0 = 24'h9a12a2, PAL1 = 24'h000000 and PAL2 = 24'hdcdcd9, giving the RGB value of palette indices 0, 1 and 2.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-005 The block SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit: a request to begin a load.
REQ-007 The block SHALL have port pix_valid, input, 1 bit: the source presents a pixel.
REQ-008 The block SHALL have port pix_rgb, input, 24 bits: the pixel colour, RGB888.
REQ-009 The block SHALL have port pix_ready, output, 1 bit: the block accepts a pixel this cycle.
REQ-010 The block SHALL have port wr_en, output, 1 bit: the write strobe to the sprite index RAM.
REQ-011 The block SHALL have port wr_addr, output, 10 bits: the index RAM write address.
REQ-012 The block SHALL have port wr_data, output, 4 bits: the palette index to write.
REQ-013 The block SHALL have port busy, output, 1 bit: a load is in progress.
REQ-014 The block SHALL have port done, output, 1 bit: a one-cycle pulse at the end of a load.
REQ-015 The block SHALL have port err, output, 1 bit: a sticky flag marking an unmatched colour.
REQ-016 The block SHALL have port err_addr, output, 10 bits: the address of the first unmatched pixel.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD and FIN.
REQ-018 In IDLE, start=1 SHALL move the FSM to LOAD, clear the pixel counter, err and err_addr, and set busy=1 on the next cycle.
REQ-019 pix_ready SHALL be 1 only in state LOAD, and a pixel is accepted exactly when pix_valid=1 and pix_ready=1 in the same cycle.
REQ-020 pix_valid=1 while pix_ready=0 SHALL have no effect and SHALL NOT be counted.
REQ-021 An accepted pixel SHALL be encoded by exact 24-bit compare against PAL0..PAL(NCOL-1), with the lowest matching index winning.
REQ-022 A pixel accepted in cycle N SHALL produce wr_en=1 in cycle N+1, with wr_addr equal to the counter value at acceptance and wr_data equal to the encoded index (registered, latency 1).
REQ-023 wr_en SHALL be 0 in every cycle not following an acceptance.
REQ-024 On an unmatched colour, the block SHALL write index 4'h0, set err=1, and capture err_addr only if err was previously 0.
REQ-025 The counter SHALL increment by 1 per accepted pixel; acceptance at count DEPTH-1 SHALL move the FSM to FIN, and the counter SHALL never wrap or exceed DEPTH-1.
REQ-026 In FIN, the cycle carrying the final wr_en (wr_addr=DEPTH-1) SHALL assert done=1, and the FSM SHALL return to IDLE on the next edge with busy=0.
REQ-027 start SHALL be ignored in LOAD and FIN, so that a load in progress is not restarted.
REQ-028 start and a first pix_valid arriving in the same cycle in IDLE SHALL NOT accept the pixel, because pix_ready is 0 in IDLE.
REQ-029 err and err_addr SHALL hold their values after done until the next accepted start.
REQ-030 Back-to-back pixels (pix_valid held at 1) SHALL be accepted every cycle with no bubbles.

Reset
REQ-031 Reset_n=0 SHALL asynchronously force state IDLE, counter=0, pix_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, err=0 and err_addr=0.
REQ-032 Reset asserted mid-LOAD SHALL abort the load, suppress any pending write (wr_en=0), and leave the block requiring a new start.
REQ-033 Reset deassertion SHALL be sampled so that the first state change occurs no earlier than the first rising Clk edge after release.

Structure
REQ-034 The package sprite_pkg SHALL hold the rgb_t (24-bit) and pal_idx_t (4-bit) typedefs, the BOARD_DEPTH=816 and SPRITE_ADDR_W=10 constants, and the loader_state_t enum.
REQ-035 The combinational RGB-to-index compare SHALL be one sub-module, palette_encoder (inputs rgb; outputs idx and hit), parameterised by NCOL and PAL0..PAL2.
REQ-036 The index RAM SHALL be external to this block; this block drives only its write port.

Verification
REQ-037 Scenario 1: start, then 816 pixels with pix_valid held at 1 cycling 9a12a2/000000/dcdcd9 -> wr_data sequence 0,1,2,... at addresses 0..815, done high exactly once with wr_addr=815, err=0.
REQ-038 Scenario 2: pix_valid toggling randomly (seed 1) during a full load -> exactly 816 wr_en pulses, with addresses contiguous and no duplicates.
REQ-039 Scenario 3: colours 123456 at address 5 and ffffff at address 9 -> wr_data=0 at both, err=1, err_addr=5.
REQ-040 Scenario 4: start pulsed at count 100 of a load -> ignored, and the load completes at 815 unchanged.
REQ-041 Scenario 5: Reset_n dropped at count 300 -> all outputs 0 immediately, no wr_en follows, and a new start loads from address 0.
REQ-042 Scenario 6: start and pix_valid asserted in the same IDLE cycle -> pixel not accepted, and first write at address 0 carries the next pixel presented.
